bus_cycle_ctrl: RTL and testbench
=================================

# bus_cycle_ctrl

Bus cycle controller for the 8086-style processor: consumes the 20-bit physical address produced by the address generation unit (segment × 16 + offset) plus an access request from the execution/prefetch logic, and runs T1–T4 memory bus cycles on a 16-bit, non-multiplexed external bus with wait states and timeout. Odd-aligned word accesses are split into two byte cycles. Sits directly downstream of the address generation unit and upstream of the external memory interface.

## Interface
- ADDR_W, 20, physical address width
- DATA_W, 16, data bus width
- MAX_WAIT, 15, maximum wait states (TW) tolerated per bus cycle before abort
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  access request present
- req_ready  out  1  controller accepts request this cycle
- req_addr  in  ADDR_W  physical address from address generation unit
- req_write  in  1  1 = write, 0 = read
- req_word  in  1  1 = 16-bit access, 0 = byte
- req_wdata  in  DATA_W  write data, byte in [7:0] for byte writes
- resp_valid  out  1  one-cycle pulse, access complete
- resp_rdata  out  DATA_W  read data, right-aligned; byte reads zero-extended
- resp_err  out  1  valid with resp_valid; 1 = wait-state timeout
- mem_addr  out  ADDR_W  external address
- ale  out  1  address latch enable
- rd_n, wr_n  out  1 each  active-low strobes
- bhe_n  out  1  active-low bus high enable
- mem_wdata  out  DATA_W  write data on bus
- mem_wdata_oe  out  1  write data drive enable
- mem_rdata  in  DATA_W  read data from bus
- mem_ready  in  1  memory ready, 0 inserts wait state

## Operation
- States: IDLE, T1, T2, T3, TW, T4.
- IDLE: req_ready = 1 (0 while rst high); on req_valid, latch addr/write/word/wdata, compute split = req_word & req_addr[0], go T1.
- T1: ale = 1, mem_addr and bhe_n driven (held stable until T4 ends); → T2.
- T2: rd_n = 0 (read) or wr_n = 0 and mem_wdata_oe = 1 (write); → T3.
- T3/TW: strobes held; if mem_ready = 1, capture mem_rdata lanes, → T4; else → TW, increment wait counter; counter reaching MAX_WAIT with mem_ready = 0 → T4 with error flag set.
- T4: strobes and oe deassert; if split pending and no error, go T1 for second cycle at (addr + 1) mod 2^20; else resp_valid = 1, → IDLE.
- Lane rules: even byte: A0 = 0, bhe_n = 1, low lane. Odd byte: A0 = 1, bhe_n = 0, high lane. Even word: A0 = 0, bhe_n = 0, both lanes. Odd word: cycle 1 at addr (high lane = word low byte), cycle 2 at addr+1 (low lane = word high byte).
- Write data: byte data replicated on both lanes; even word = req_wdata unchanged.
- Error: resp_rdata = 0, resp_err = 1; second half of split skipped.
- Wait counter clears at every T1.

## Timing
- Reset values: state IDLE, ale 0, rd_n 1, wr_n 1, bhe_n 1, mem_addr 0, mem_wdata 0, mem_wdata_oe 0, resp_valid 0, resp_rdata 0, resp_err 0.
- Zero-wait latency: accept edge → T1, T2, T3, T4; resp_valid high in T4 (4 cycles after accept). Split: 8 cycles. Each TW adds 1.
- resp_rdata/resp_err stable from T4 until next resp_valid.
- Next request accepted the cycle after T4 (IDLE); no overlap.
- rst mid-cycle: next edge returns to IDLE with reset outputs; no resp_valid for aborted access.
- Address wrap: odd word at 0xFFFFF → second cycle at 0x00000.
- mem_ready ignored outside T3/TW.

## Structure
- Package bus_pkg: state enum, ADDR_W/DATA_W constants, bhe_n/A0 lane encodings.
- Sub-module bus_lane_steer (combinational): maps address bit 0, word, split phase to bhe_n, write-lane replication and read-lane extraction.
- Top holds FSM, request latch, wait counter, read assembly register.

## Test plan
- Even word read 0x12340, mem_ready = 1, mem_rdata = 0xBEEF -> ale in T1, bhe_n = 0, resp_valid 4 cycles after accept, resp_rdata = 0xBEEF.
- Odd byte write 0x00101 data 0x5A -> mem_addr 0x00101, bhe_n = 0, mem_wdata = 0x5A5A, wr_n low T2–T3, resp_err = 0.
- Odd word read 0xFFFFF, first cycle high lane 0x34, second (mem_addr 0x00000) low lane 0x12 -> resp_rdata = 0x1234 after 8 cycles.
- Even word read with mem_ready = 0 for 3 cycles -> 3 TW states, resp_valid 7 cycles after accept.
- mem_ready held 0 -> abort after MAX_WAIT waits, resp_err = 1, resp_rdata = 0, rd_n back to 1.
- rst asserted during T2 of a write -> next cycle wr_n = 1, mem_wdata_oe = 0, IDLE, no resp_valid.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the 8086-style bus cycle controller.
// Lane encodings name the active-low BHE# level and the meaning of address bit 0.
package bus_pkg;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 15;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4
  } bus_state_e;

  localparam logic BHE_ON  = 1'b0;
  localparam logic BHE_OFF = 1'b1;
  localparam logic A0_ODD  = 1'b1;

endpackage

// File: rtl/bus_lane_steer.sv
// Byte-lane steering for one bus cycle: BHE# generation, write-lane replication
// and read-lane extraction, including the two halves of a split odd word.
module bus_lane_steer
  import bus_pkg::*;
(
  input  logic              a0,
  input  logic              word,
  input  logic              split,
  input  logic              phase,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic [7:0]        asm_lo,
  output logic              bhe_n,
  output logic [DATA_W-1:0] wdata_bus,
  output logic [7:0]        rd_byte,
  output logic [DATA_W-1:0] rd_result
);

  logic       byte_mode;
  logic [7:0] wr_byte;

  always_comb begin
    // Each half of a split word behaves exactly like a byte cycle at its own address.
    byte_mode = ~word | split;
    wr_byte   = phase ? wdata[15:8] : wdata[7:0];
    rd_byte   = (a0 == A0_ODD) ? rdata[15:8] : rdata[7:0];

    if (byte_mode) begin
      bhe_n     = (a0 == A0_ODD) ? BHE_ON : BHE_OFF;
      wdata_bus = {wr_byte, wr_byte};
      rd_result = split ? {rd_byte, asm_lo} : {8'h00, rd_byte};
    end else begin
      bhe_n     = BHE_ON;
      wdata_bus = wdata;
      rd_result = rdata;
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// T1-T4 bus cycle controller with wait states, timeout abort and
// odd-word splitting into two byte cycles on a 16-bit non-multiplexed bus.
module bus_cycle_ctrl
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              req_word,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ale,
  output logic              rd_n,
  output logic              wr_n,
  output logic              bhe_n,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  bus_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic              word_q, word_d;
  logic              split_q, split_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        asm_lo_q, asm_lo_d;

  logic              ale_q, ale_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              bhe_n_q, bhe_n_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  // Cycle being launched (IDLE, T4) or currently on the bus (T1..TW).
  logic [ADDR_W-1:0] cyc_addr;
  logic              cyc_word, cyc_split, cyc_phase;
  logic [DATA_W-1:0] cyc_wdata;

  logic              st_bhe_n;
  logic [DATA_W-1:0] st_wdata, st_rd_result;
  logic [7:0]        st_rd_byte;

  always_comb begin
    cyc_addr  = mem_addr_q;
    cyc_word  = word_q;
    cyc_split = split_q;
    cyc_phase = phase_q;
    cyc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      cyc_addr  = req_addr;
      cyc_word  = req_word;
      cyc_split = req_word & req_addr[0];
      cyc_phase = 1'b0;
      cyc_wdata = req_wdata;
    end else if (state_q == S_T4) begin
      cyc_addr  = addr_q + ADDR_W'(1);
      cyc_phase = 1'b1;
    end
  end

  bus_lane_steer u_steer (
    .a0        (cyc_addr[0]),
    .word      (cyc_word),
    .split     (cyc_split),
    .phase     (cyc_phase),
    .wdata     (cyc_wdata),
    .rdata     (mem_rdata),
    .asm_lo    (asm_lo_q),
    .bhe_n     (st_bhe_n),
    .wdata_bus (st_wdata),
    .rd_byte   (st_rd_byte),
    .rd_result (st_rd_result)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case can infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    word_d       = word_q;
    split_d      = split_q;
    phase_d      = phase_q;
    wdata_d      = wdata_q;
    wait_d       = wait_q;
    asm_lo_d     = asm_lo_q;
    ale_d        = ale_q;
    rd_n_d       = rd_n_q;
    wr_n_d       = wr_n_q;
    bhe_n_d      = bhe_n_q;
    oe_d         = oe_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          write_d     = req_write;
          word_d      = req_word;
          split_d     = cyc_split;
          wdata_d     = req_wdata;
          phase_d     = 1'b0;
          state_d     = S_T1;
          ale_d       = 1'b1;
          mem_addr_d  = cyc_addr;
          bhe_n_d     = st_bhe_n;
          mem_wdata_d = st_wdata;
          wait_d      = '0;
        end
      end
      S_T1: begin
        state_d = S_T2;
        ale_d   = 1'b0;
        rd_n_d  = write_q;
        wr_n_d  = ~write_q;
        oe_d    = write_q;
      end
      S_T2: state_d = S_T3;
      S_T3, S_TW: begin
        if (mem_ready) begin
          state_d = S_T4;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          oe_d    = 1'b0;
          if (split_q && !phase_q) begin
            asm_lo_d = st_rd_byte;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = write_q ? '0 : st_rd_result;
          end
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          state_d      = S_T4;
          rd_n_d       = 1'b1;
          wr_n_d       = 1'b1;
          oe_d         = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d = S_TW;
          wait_d  = wait_q + 1'b1;
        end
      end
      S_T4: begin
        // A response issued on entry to T4 means nothing is left to run.
        if (resp_valid_q) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_T1;
          phase_d     = 1'b1;
          ale_d       = 1'b1;
          mem_addr_d  = cyc_addr;
          bhe_n_d     = st_bhe_n;
          mem_wdata_d = st_wdata;
          wait_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      word_q       <= 1'b0;
      split_q      <= 1'b0;
      phase_q      <= 1'b0;
      wdata_q      <= '0;
      wait_q       <= '0;
      asm_lo_q     <= '0;
      ale_q        <= 1'b0;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      bhe_n_q      <= BHE_OFF;
      oe_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      word_q       <= word_d;
      split_q      <= split_d;
      phase_q      <= phase_d;
      wdata_q      <= wdata_d;
      wait_q       <= wait_d;
      asm_lo_q     <= asm_lo_d;
      ale_q        <= ale_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      bhe_n_q      <= bhe_n_d;
      oe_q         <= oe_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_addr     = mem_addr_q;
  assign ale          = ale_q;
  assign rd_n         = rd_n_q;
  assign wr_n         = wr_n_q;
  assign bhe_n        = bhe_n_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wdata_oe = oe_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: a table of accesses with hand-computed
// bus and response values, plus reset and mid-cycle reset sequences.
module tb_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_addr;
  logic        req_write;
  logic        req_word;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [19:0] mem_addr;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic        bhe_n;
  logic [15:0] mem_wdata;
  logic        mem_wdata_oe;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  bus_cycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_word     (req_word),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .ale          (ale),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .bhe_n        (bhe_n),
    .mem_wdata    (mem_wdata),
    .mem_wdata_oe (mem_wdata_oe),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic        write;
    logic        word;
    logic [15:0] wdata;
    logic [15:0] rd1;
    logic [15:0] rd2;
    int          waits;
    int          exp_lat;
    int          exp_cyc;
    int          exp_s1;
    logic [19:0] exp_a1;
    logic        exp_b1;
    logic [15:0] exp_w1;
    logic [19:0] exp_a2;
    logic        exp_b2;
    logic [15:0] exp_w2;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one request, plays the memory side and compares everything observed.
  task automatic run_access(input int idx, input vec_t v);
    int          s, cyc, s1, lat;
    bit          done, saw_rd, saw_wr, oe_ok, stable;
    logic [19:0] a1, a2;
    logic        b1, b2;
    logic [15:0] w1, w2, rdata;
    logic        err, ready_t4;
    string       p;
    p = $sformatf("v%0d_", idx);
    s = 0; cyc = 0; s1 = 0; lat = -1; done = 0;
    saw_rd = 0; saw_wr = 0; oe_ok = 1; stable = 1;
    a1 = '0; a2 = '0; b1 = 1'b1; b2 = 1'b1; w1 = '0; w2 = '0;
    rdata = '0; err = 1'b0; ready_t4 = 1'b1;

    @(negedge clk);
    check({p, "ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.write;
    req_word  = v.word;
    req_wdata = v.wdata;
    mem_ready = 1'b0;
    mem_rdata = v.rd1;

    for (int e = 1; e <= 60 && !done; e++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (ale) begin
        cyc++;
        s = 0;
        if (cyc == 1) begin a1 = mem_addr; b1 = bhe_n; end
        if (cyc == 2) begin a2 = mem_addr; b2 = bhe_n; end
      end
      if (!rd_n || !wr_n) begin
        s++;
        if (cyc == 1) s1 = s;
        if (s == 1 && cyc == 1) w1 = mem_wdata;
        if (s == 1 && cyc == 2) w2 = mem_wdata;
        if (!rd_n) saw_rd = 1;
        if (!wr_n) begin
          saw_wr = 1;
          if (!mem_wdata_oe) oe_ok = 0;
        end
        if ((cyc == 1 && mem_addr !== a1) || (cyc == 2 && mem_addr !== a2)) stable = 0;
      end
      mem_rdata = (cyc == 2) ? v.rd2 : v.rd1;
      // T2 presents ready=1, which must be ignored there.
      mem_ready = (s == 1) || (s >= 2 + v.waits);
      if (resp_valid) begin
        done     = 1;
        lat      = e;
        rdata    = resp_rdata;
        err      = resp_err;
        ready_t4 = req_ready;
      end
    end

    check({p, "latency"}, lat, v.exp_lat);
    check({p, "cycles"}, cyc, v.exp_cyc);
    check({p, "strobes1"}, s1, v.exp_s1);
    check({p, "addr1"}, a1, v.exp_a1);
    check({p, "bhe1"}, b1, v.exp_b1);
    check({p, "addr_stable"}, stable, 1);
    check({p, "saw_wr"}, saw_wr, v.write);
    check({p, "saw_rd"}, saw_rd, !v.write);
    check({p, "err"}, err, v.exp_err);
    check({p, "ready_t4"}, ready_t4, 0);
    if (v.write) begin
      check({p, "wdata1"}, w1, v.exp_w1);
      check({p, "oe"}, oe_ok, 1);
    end else begin
      check({p, "rdata"}, rdata, v.exp_rd);
    end
    if (v.exp_cyc == 2) begin
      check({p, "addr2"}, a2, v.exp_a2);
      check({p, "bhe2"}, b2, v.exp_b2);
      if (v.write) check({p, "wdata2"}, w2, v.exp_w2);
    end

    @(negedge clk);
    check({p, "pulse_end"}, resp_valid, 0);
    check({p, "rdata_hold"}, resp_rdata, rdata);
    check({p, "ready_after"}, req_ready, 1);
    check({p, "strobes_off"}, {rd_n, wr_n, mem_wdata_oe}, 3'b110);
  endtask

  initial begin
    int rv_cnt;
    bit hit_t2;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_word  = 1'b0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    // addr wr wd wdata rd1 rd2 waits | lat cyc s1 a1 b1 w1 a2 b2 w2 rd err
    vecs[0]  = '{20'h12340, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 16'h0000, 0,   4,  1, 2,  20'h12340, 1'b0, 16'h0000, 20'h00000, 1'b1, 16'h0000, 16'hBEEF, 1'b0};
    vecs[1]  = '{20'h00101, 1'b1, 1'b0, 16'h115A, 16'h0000, 16'h0000, 0,   4,  1, 2,  20'h00101, 1'b0, 16'h5A5A, 20'h00000, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{20'hFFFFF, 1'b0, 1'b1, 16'h0000, 16'h3499, 16'h7712, 0,   8,  2, 2,  20'hFFFFF, 1'b0, 16'h0000, 20'h00000, 1'b1, 16'h0000, 16'h1234, 1'b0};
    vecs[3]  = '{20'h0A0A0, 1'b0, 1'b1, 16'h0000, 16'hCAFE, 16'h0000, 3,   7,  1, 5,  20'h0A0A0, 1'b0, 16'h0000, 20'h00000, 1'b1, 16'h0000, 16'hCAFE, 1'b0};
    vecs[4]  = '{20'h00200, 1'b0, 1'b0, 16'h0000, 16'h4455, 16'h0000, 100, 19, 1, 17, 20'h00200, 1'b1, 16'h0000, 20'h00000, 1'b1, 16'h0000, 16'h0000, 1'b1};
    vecs[5]  = '{20'h00456, 1'b0, 1'b0, 16'h0000, 16'hAB77, 16'h0000, 0,   4,  1, 2,  20'h00456, 1'b1, 16'h0000, 20'h00000, 1'b1, 16'h0000, 16'h0077, 1'b0};
    vecs[6]  = '{20'h00457, 1'b0, 1'b0, 16'h0000, 16'hAB77, 16'h0000, 0,   4,  1, 2,  20'h00457, 1'b0, 16'h0000, 20'h00000, 1'b1, 16'h0000, 16'h00AB, 1'b0};
    vecs[7]  = '{20'h20000, 1'b1, 1'b1, 16'h1234, 16'h0000, 16'h0000, 0,   4,  1, 2,  20'h20000, 1'b0, 16'h1234, 20'h00000, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{20'h30003, 1'b1, 1'b1, 16'hA1B2, 16'h0000, 16'h0000, 1,   10, 2, 3,  20'h30003, 1'b0, 16'hB2B2, 20'h30004, 1'b1, 16'hA1A1, 16'h0000, 1'b0};
    vecs[9]  = '{20'h40010, 1'b1, 1'b0, 16'h00C3, 16'h0000, 16'h0000, 0,   4,  1, 2,  20'h40010, 1'b1, 16'hC3C3, 20'h00000, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{20'h00011, 1'b0, 1'b1, 16'h0000, 16'h9999, 16'h8888, 100, 19, 1, 17, 20'h00011, 1'b0, 16'h0000, 20'h00000, 1'b1, 16'h0000, 16'h0000, 1'b1};
    vecs[11] = '{20'h12345, 1'b0, 1'b1, 16'h0000, 16'h5600, 16'h0078, 2,   12, 2, 4,  20'h12345, 1'b0, 16'h0000, 20'h12346, 1'b1, 16'h0000, 16'h7856, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_ale", ale, 0);
    check("rst_strobes", {rd_n, wr_n, bhe_n}, 3'b111);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_oe", mem_wdata_oe, 0);
    check("rst_resp", {resp_valid, resp_err}, 2'b00);
    check("rst_rdata", resp_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_access(i, vecs[i]);

    // Reset while a write is in T2.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 20'h50000;
    req_write = 1'b1;
    req_word  = 1'b1;
    req_wdata = 16'hFFFF;
    mem_ready = 1'b1;
    hit_t2    = 0;
    for (int e = 0; e < 10 && !hit_t2; e++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (!wr_n) hit_t2 = 1;
    end
    check("mid_reached_t2", hit_t2, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_wr_n", wr_n, 1);
    check("mid_oe", mem_wdata_oe, 0);
    check("mid_ale", ale, 0);
    check("mid_wdata", mem_wdata, 0);
    check("mid_resp", resp_valid, 0);
    rst = 1'b0;
    rv_cnt = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      if (resp_valid) rv_cnt++;
    end
    check("mid_no_resp", rv_cnt, 0);
    check("mid_ready", req_ready, 1);

    run_access(12, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
